// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int BUS_W = 32;
  localparam logic [BUS_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, WAIT, REQ, RESP} state_t;
  typedef enum logic {INSTR, DATA} port_t;

  // Latched request; fields are sized by BUS_W, so SIZE_OF_THE_BUS must equal it.
  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [3:0]       wstrb;
    logic             instr;
  } req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side handshake bundle of the arbiter.
interface mem_port_arbiter_if #(parameter int SIZE_OF_THE_BUS = 32);
  logic                       i_valid;
  logic [SIZE_OF_THE_BUS-1:0] i_addr;
  logic                       i_ready;
  logic [SIZE_OF_THE_BUS-1:0] i_rdata;
  logic                       d_valid;
  logic [SIZE_OF_THE_BUS-1:0] d_addr;
  logic [SIZE_OF_THE_BUS-1:0] d_wdata;
  logic [3:0]                 d_wstrb;
  logic                       d_ready;
  logic [SIZE_OF_THE_BUS-1:0] d_rdata;
  logic                       m_valid;
  logic [SIZE_OF_THE_BUS-1:0] m_addr;
  logic [SIZE_OF_THE_BUS-1:0] m_wdata;
  logic [3:0]                 m_wstrb;
  logic                       m_instr;
  logic                       m_ready;
  logic [SIZE_OF_THE_BUS-1:0] m_rdata;
  logic                       err;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb, m_instr, err
  );
  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb, m_instr, err
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Winner selection. MEM_ARB_RR_EN: round-robin ties with a last_grant register;
// otherwise fixed priority with the data port winning ties.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic  clk,
  input  logic  reset,
  input  logic  grant_en,
`endif
  input  logic  i_valid,
  input  logic  d_valid,
  output port_t winner
);
`ifdef MEM_ARB_RR_EN
  port_t last_grant_q, last_grant_d;

  always_comb begin
    winner = (i_valid && !d_valid) ? INSTR : DATA;
    if (i_valid && d_valid) winner = (last_grant_q == DATA) ? INSTR : DATA;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_en) last_grant_d = winner;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= INSTR;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign winner = (i_valid && !d_valid) ? INSTR : DATA;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one native memory port with wait
// states and a ready timeout. Tie policy selected by MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                         SIZE_OF_THE_BUS = BUS_W,
  parameter int                         WAIT_CYCLES     = 0,
  parameter int                         TIMEOUT         = 64,
  parameter logic [SIZE_OF_THE_BUS-1:0] ERR_DATA        = ERR_DATA_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  state_t                     state_q, state_d;
  req_t                       req_q, req_d;
  port_t                      owner_q, owner_d;
  logic [3:0]                 wait_cnt_q, wait_cnt_d;
  logic [31:0]                tmo_cnt_q, tmo_cnt_d;
  logic                       err_q, err_d;
  logic [SIZE_OF_THE_BUS-1:0] i_rdata_q, i_rdata_d;
  logic [SIZE_OF_THE_BUS-1:0] d_rdata_q, d_rdata_d;
  logic [SIZE_OF_THE_BUS-1:0] cap;
  logic                       tmo_hit;
  logic                       grant_en;
  port_t                      winner;

  assign grant_en = (state_q == IDLE) && (bus.i_valid || bus.d_valid);

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
`endif
    .i_valid  (bus.i_valid),
    .d_valid  (bus.d_valid),
    .winner   (winner)
  );

  // m_ready takes precedence over a timeout firing in the same cycle.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == 32'(TIMEOUT - 1));
  assign cap     = bus.m_ready ? bus.m_rdata : ERR_DATA;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: if (grant_en) begin
        owner_d    = winner;
        err_d      = 1'b0;
        tmo_cnt_d  = '0;
        wait_cnt_d = 4'(WAIT_CYCLES);
        if (winner == DATA)
          req_d = '{addr: bus.d_addr, wdata: bus.d_wdata, wstrb: bus.d_wstrb, instr: 1'b0};
        else
          req_d = '{addr: bus.i_addr, wdata: '0, wstrb: 4'b0000, instr: 1'b1};
        state_d = (WAIT_CYCLES == 0) ? REQ : WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = REQ;
      end
      REQ: begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (bus.m_ready || tmo_hit) begin
          state_d = RESP;
          err_d   = !bus.m_ready;
          if (owner_q == DATA) d_rdata_d = cap;
          else                 i_rdata_d = cap;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      owner_q    <= INSTR;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.m_valid = (state_q == REQ);
  assign bus.m_addr  = req_q.addr;
  assign bus.m_wdata = req_q.wdata;
  assign bus.m_wstrb = req_q.wstrb;
  assign bus.m_instr = req_q.instr;
  assign bus.i_ready = (state_q == RESP) && (owner_q == INSTR);
  assign bus.d_ready = (state_q == RESP) && (owner_q == DATA);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.err     = (state_q == RESP) && err_q;
endmodule
